// File: rtl/cond_it_unit.sv
// cond_it_unit
// Conditional-execution unit. It evaluates ARM condition codes against one of
// NCTX = 2**CTXW banked NZCV flag contexts, gates the register, memory and PC
// write requests of the main control FSM, and sequences Thumb-style IT blocks
// of up to ITMAX instructions. A single saved-flags register supports
// exception entry (save) and return (restore).
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   Cond, ALUFlags, FlagW      condition field, ALU {N,Z,C,V}, flag write request
//   PCS, NextPC, RegW, MemW    raw write requests
//   CondLatch, InstrDone       latch CondEx into CondExR; retire strobe
//   CtxSel                     active flag context
//   ITStart, ITBase, ITLen,
//   ITPat                      IT block load: base cond, length, then/else mask
//   SaveFlags, RestoreFlags    exception entry / return
//   PCWrite, RegWrite,
//   MemWrite                   gated write enables
//   CondEx, CondExR            live and latched condition result
//   Flags, SavedFlags          selected context flags, saved flags
//   ITActive, ITRemain, ITErr  IT status; ITErr pulses on a rejected ITStart
module cond_it_unit #(
   parameter int CTXW  = 1,
   parameter int ITMAX = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      Cond,
   input  logic [3:0]      ALUFlags,
   input  logic [1:0]      FlagW,
   input  logic            PCS,
   input  logic            NextPC,
   input  logic            RegW,
   input  logic            MemW,
   input  logic            CondLatch,
   input  logic            InstrDone,
   input  logic [CTXW-1:0] CtxSel,
   input  logic            ITStart,
   input  logic [3:0]      ITBase,
   input  logic [2:0]      ITLen,
   input  logic [2:0]      ITPat,
   input  logic            SaveFlags,
   input  logic            RestoreFlags,
   output logic            PCWrite,
   output logic            RegWrite,
   output logic            MemWrite,
   output logic            CondEx,
   output logic            CondExR,
   output logic [3:0]      Flags,
   output logic [3:0]      SavedFlags,
   output logic            ITActive,
   output logic [2:0]      ITRemain,
   output logic            ITErr
);

   localparam int unsigned NCTX = 2**CTXW;

   typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_t;

   it_state_t  state_q, state_d;

   logic [3:0] ctx_q [NCTX];
   logic [3:0] saved_q;
   logic       condexr_q;
   logic [2:0] remain_q;
   logic [2:0] pat_q;
   logic [3:0] base_q;
   logic [3:0] itcond_q;
   logic       iterr_q;

   logic [3:0] cur_flags;
   logic [3:0] eff_cond;
   logic       condex;
   logic [1:0] flagwrite;
   logic       len_ok;
   logic       it_load;
   logic       it_adv;
   logic       it_inv;
   logic [3:0] it_next_cond;

   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c)
         4'b0000: cond_eval = z;
         4'b0001: cond_eval = ~z;
         4'b0010: cond_eval = cf;
         4'b0011: cond_eval = ~cf;
         4'b0100: cond_eval = n;
         4'b0101: cond_eval = ~n;
         4'b0110: cond_eval = v;
         4'b0111: cond_eval = ~v;
         4'b1000: cond_eval = cf & ~z;
         4'b1001: cond_eval = ~(cf & ~z);
         4'b1010: cond_eval = (n == v);
         4'b1011: cond_eval = (n != v);
         4'b1100: cond_eval = ~z & (n == v);
         4'b1101: cond_eval = ~(~z & (n == v));
         default: cond_eval = 1'b1;
      endcase
   endfunction

   // Condition evaluation and write gating
   always_comb begin
      cur_flags = ctx_q[CtxSel];
      eff_cond  = (state_q == IT_ACTIVE) ? itcond_q : Cond;
      condex    = cond_eval(eff_cond, cur_flags);
      flagwrite = FlagW & {2{condex}};
      len_ok    = (ITLen != 3'd0) && (ITLen <= 3'(ITMAX));
      it_load   = ITStart && (state_q == IT_IDLE) && len_ok;
      it_adv    = InstrDone && (state_q == IT_ACTIVE);
      // The AL/NV base has no meaningful inverse, so else-slots keep the base.
      it_inv       = (base_q[3:1] != 3'b111) && !pat_q[0];
      it_next_cond = {base_q[3:1], base_q[0] ^ it_inv};
   end

   // IT sequencer: state register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IT_IDLE;
      else        state_q <= state_d;
   end

   // IT sequencer: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IT_IDLE:   if (it_load) state_d = IT_ACTIVE;
         IT_ACTIVE: if (it_adv && (remain_q == 3'd1)) state_d = IT_IDLE;
         default:   state_d = IT_IDLE;
      endcase
   end

   // IT sequencer: outputs and gated enables
   always_comb begin
      ITActive   = (state_q == IT_ACTIVE);
      ITRemain   = remain_q;
      ITErr      = iterr_q;
      CondEx     = condex;
      CondExR    = condexr_q;
      Flags      = cur_flags;
      SavedFlags = saved_q;
      RegWrite   = RegW & condex;
      MemWrite   = MemW & condex;
      PCWrite    = (PCS & condexr_q) | NextPC;
   end

   // IT datapath. An ITStart seen while active, or with a bad length, is
   // dropped; a same-cycle InstrDone still advances an active block.
   always_ff @(posedge clk) begin
      if (!reset) begin
         remain_q <= '0;
         pat_q    <= '0;
         base_q   <= '0;
         itcond_q <= '0;
         iterr_q  <= 1'b0;
      end else begin
         iterr_q <= ITStart && ((state_q == IT_ACTIVE) || !len_ok);
         if (it_load) begin
            remain_q <= ITLen;
            pat_q    <= ITPat;
            base_q   <= ITBase;
            itcond_q <= ITBase;
         end else if (it_adv) begin
            remain_q <= remain_q - 3'd1;
            pat_q    <= pat_q >> 1;
            if (remain_q > 3'd1) itcond_q <= it_next_cond;
         end
      end
   end

   // Flag contexts, saved flags and latched condition. Restore overrides any
   // same-cycle flag write; save always samples the pre-edge context value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NCTX; i++) ctx_q[i] <= '0;
         saved_q   <= '0;
         condexr_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NCTX; i++) begin
            if (CtxSel == CTXW'(i)) begin
               if (RestoreFlags) begin
                  ctx_q[i] <= saved_q;
               end else begin
                  if (flagwrite[1]) ctx_q[i][3:2] <= ALUFlags[3:2];
                  if (flagwrite[0]) ctx_q[i][1:0] <= ALUFlags[1:0];
               end
            end
         end
         if (SaveFlags) saved_q   <= cur_flags;
         if (CondLatch) condexr_q <= condex;
      end
   end

endmodule

// File: tb/tb_cond_it_unit.sv
module tb_cond_it_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, ALUFlags, ITBase;
   logic [1:0] FlagW;
   logic       PCS, NextPC, RegW, MemW, CondLatch, InstrDone;
   logic [0:0] CtxSel;
   logic       ITStart, SaveFlags, RestoreFlags;
   logic [2:0] ITLen, ITPat;
   logic       PCWrite, RegWrite, MemWrite, CondEx, CondExR, ITActive, ITErr;
   logic [3:0] Flags, SavedFlags;
   logic [2:0] ITRemain;

   always #5 clk = ~clk;

   cond_it_unit #(.CTXW(1), .ITMAX(4)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CondLatch(CondLatch),
      .InstrDone(InstrDone), .CtxSel(CtxSel), .ITStart(ITStart), .ITBase(ITBase),
      .ITLen(ITLen), .ITPat(ITPat), .SaveFlags(SaveFlags), .RestoreFlags(RestoreFlags),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .CondExR(CondExR), .Flags(Flags), .SavedFlags(SavedFlags), .ITActive(ITActive),
      .ITRemain(ITRemain), .ITErr(ITErr)
   );

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] cond, alu, base;
      logic [1:0] fw;
      logic       pcs, npc, regw, memw, latch, done, ctx, itstart, save, restore;
      logic [2:0] len, pat;
      logic [17:0] exp;  // {CondEx,RegWrite,MemWrite,PCWrite,CondExR,ITActive,ITErr,ITRemain,Flags,SavedFlags}
   } vec_t;

   vec_t        tbl[$];
   vec_t        v;
   logic [17:0] exp_q[$];
   string       name_q[$];
   logic [3:0]  it_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic vec_t d(input string n);
      vec_t r;
      r.name = n; r.rst = 1'b1; r.cond = 4'hE; r.alu = 4'h0; r.base = 4'h0; r.fw = 2'b00;
      r.pcs = 1'b0; r.npc = 1'b0; r.regw = 1'b0; r.memw = 1'b0; r.latch = 1'b0; r.done = 1'b0;
      r.ctx = 1'b0; r.itstart = 1'b0; r.save = 1'b0; r.restore = 1'b0; r.len = 3'd0; r.pat = 3'd0;
      r.exp = '0;
      return r;
   endfunction

   function automatic logic [17:0] ex(input int ce, rw, mw, pcw, cr, act, err, rem, fl, sv);
      logic [31:0] a, b, c;
      a = rem; b = fl; c = sv;
      return {ce[0], rw[0], mw[0], pcw[0], cr[0], act[0], err[0], a[2:0], b[3:0], c[3:0]};
   endfunction

   task automatic drive(input vec_t t);
      reset = t.rst; Cond = t.cond; ALUFlags = t.alu; FlagW = t.fw; PCS = t.pcs; NextPC = t.npc;
      RegW = t.regw; MemW = t.memw; CondLatch = t.latch; InstrDone = t.done; CtxSel = t.ctx;
      ITStart = t.itstart; ITBase = t.base; ITLen = t.len; ITPat = t.pat;
      SaveFlags = t.save; RestoreFlags = t.restore;
   endtask

   initial begin
      logic [17:0] got, e;
      logic [3:0]  it_got, it_e;
      string       n;
      int          budget;

      // Reset and basic gating
      v=d("reset_state"); v.rst=1'b0; v.cond=4'h0; v.regw=1'b1; v.exp=ex(0,0,0,0,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      v=d("pc_nextpc"); v.npc=1'b1; v.pcs=1'b1; v.regw=1'b1; v.memw=1'b1; v.exp=ex(1,1,1,1,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      v=d("pcs_no_latch"); v.pcs=1'b1; v.exp=ex(1,0,0,0,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      v=d("flag_write"); v.alu=4'h4; v.fw=2'b11; v.regw=1'b1; v.exp=ex(1,1,0,0,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      v=d("eq_taken"); v.cond=4'h0; v.regw=1'b1; v.memw=1'b1; v.exp=ex(1,1,1,0,0,0,0,0,4'h4,4'h0); tbl.push_back(v);
      v=d("ne_gated_write"); v.cond=4'h1; v.alu=4'hB; v.fw=2'b11; v.regw=1'b1; v.exp=ex(0,0,0,0,0,0,0,0,4'h4,4'h0); tbl.push_back(v);
      v=d("nz_only"); v.alu=4'hB; v.fw=2'b10; v.exp=ex(1,0,0,0,0,0,0,0,4'h4,4'h0); tbl.push_back(v);
      v=d("cv_only"); v.alu=4'h3; v.fw=2'b01; v.exp=ex(1,0,0,0,0,0,0,0,4'h8,4'h0); tbl.push_back(v);
      // Latched condition
      v=d("ge_latch"); v.cond=4'hA; v.latch=1'b1; v.exp=ex(1,0,0,0,0,0,0,0,4'hB,4'h0); tbl.push_back(v);
      v=d("pcs_latched"); v.cond=4'hB; v.pcs=1'b1; v.exp=ex(0,0,0,1,1,0,0,0,4'hB,4'h0); tbl.push_back(v);
      v=d("latch_zero"); v.cond=4'hB; v.pcs=1'b1; v.latch=1'b1; v.exp=ex(0,0,0,1,1,0,0,0,4'hB,4'h0); tbl.push_back(v);
      v=d("pcs_cleared"); v.pcs=1'b1; v.exp=ex(1,0,0,0,0,0,0,0,4'hB,4'h0); tbl.push_back(v);
      // Flag contexts
      v=d("ctx0_set"); v.alu=4'h8; v.fw=2'b11; v.exp=ex(1,0,0,0,0,0,0,0,4'hB,4'h0); tbl.push_back(v);
      v=d("ctx1_set"); v.ctx=1'b1; v.alu=4'h2; v.fw=2'b11; v.exp=ex(1,0,0,0,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      v=d("ctx1_mi"); v.ctx=1'b1; v.cond=4'h4; v.regw=1'b1; v.exp=ex(0,0,0,0,0,0,0,0,4'h2,4'h0); tbl.push_back(v);
      v=d("ctx0_mi"); v.cond=4'h4; v.regw=1'b1; v.exp=ex(1,1,0,0,0,0,0,0,4'h8,4'h0); tbl.push_back(v);
      v=d("ctx1_mi_hold"); v.ctx=1'b1; v.cond=4'h4; v.regw=1'b1; v.exp=ex(0,0,0,0,0,0,0,0,4'h2,4'h0); tbl.push_back(v);
      // Save / restore
      v=d("ctx0_load9"); v.alu=4'h9; v.fw=2'b11; v.exp=ex(1,0,0,0,0,0,0,0,4'h8,4'h0); tbl.push_back(v);
      v=d("save"); v.save=1'b1; v.alu=4'h6; v.fw=2'b11; v.exp=ex(1,0,0,0,0,0,0,0,4'h9,4'h0); tbl.push_back(v);
      v=d("swap"); v.save=1'b1; v.restore=1'b1; v.exp=ex(1,0,0,0,0,0,0,0,4'h6,4'h9); tbl.push_back(v);
      v=d("restore_wins"); v.restore=1'b1; v.fw=2'b11; v.alu=4'hF; v.exp=ex(1,0,0,0,0,0,0,0,4'h9,4'h6); tbl.push_back(v);
      v=d("after_restore"); v.exp=ex(1,0,0,0,0,0,0,0,4'h6,4'h6); tbl.push_back(v);
      // IT block EQ,NE,EQ with Z=1
      v=d("it_start"); v.itstart=1'b1; v.base=4'h0; v.len=3'd3; v.pat=3'b010; v.regw=1'b1; v.exp=ex(1,1,0,0,0,0,0,0,4'h6,4'h6); tbl.push_back(v);
      v=d("it_i1_eq"); v.cond=4'h1; v.regw=1'b1; v.done=1'b1; v.exp=ex(1,1,0,0,0,1,0,3,4'h6,4'h6); tbl.push_back(v);
      v=d("it_i2_ne"); v.cond=4'h0; v.regw=1'b1; v.done=1'b1; v.exp=ex(0,0,0,0,0,1,0,2,4'h6,4'h6); tbl.push_back(v);
      v=d("it_i3_eq"); v.cond=4'h1; v.regw=1'b1; v.done=1'b1; v.exp=ex(1,1,0,0,0,1,0,1,4'h6,4'h6); tbl.push_back(v);
      v=d("it_done"); v.cond=4'h1; v.regw=1'b1; v.exp=ex(0,0,0,0,0,0,0,0,4'h6,4'h6); tbl.push_back(v);
      // Rejected starts
      v=d("it2_start"); v.itstart=1'b1; v.base=4'h4; v.len=3'd2; v.exp=ex(1,0,0,0,0,0,0,0,4'h6,4'h6); tbl.push_back(v);
      v=d("it_restart_rej"); v.itstart=1'b1; v.len=3'd1; v.exp=ex(0,0,0,0,0,1,0,2,4'h6,4'h6); tbl.push_back(v);
      v=d("it_err_pulse"); v.exp=ex(0,0,0,0,0,1,1,2,4'h6,4'h6); tbl.push_back(v);
      v=d("start_done_active"); v.itstart=1'b1; v.len=3'd2; v.done=1'b1; v.exp=ex(0,0,0,0,0,1,0,2,4'h6,4'h6); tbl.push_back(v);
      v=d("it_else_pl"); v.exp=ex(1,0,0,0,0,1,1,1,4'h6,4'h6); tbl.push_back(v);
      v=d("it2_last"); v.done=1'b1; v.exp=ex(1,0,0,0,0,1,0,1,4'h6,4'h6); tbl.push_back(v);
      v=d("len0_rej"); v.itstart=1'b1; v.len=3'd0; v.exp=ex(1,0,0,0,0,0,0,0,4'h6,4'h6); tbl.push_back(v);
      v=d("len5_rej"); v.itstart=1'b1; v.len=3'd5; v.exp=ex(1,0,0,0,0,0,1,0,4'h6,4'h6); tbl.push_back(v);
      v=d("len5_err"); v.exp=ex(1,0,0,0,0,0,1,0,4'h6,4'h6); tbl.push_back(v);
      v=d("start_done_idle"); v.itstart=1'b1; v.base=4'hE; v.len=3'd2; v.done=1'b1; v.cond=4'h1; v.exp=ex(0,0,0,0,0,0,0,0,4'h6,4'h6); tbl.push_back(v);
      // Reset in the middle of an IT block
      v=d("al_it_latch"); v.latch=1'b1; v.cond=4'h1; v.exp=ex(1,0,0,0,0,1,0,2,4'h6,4'h6); tbl.push_back(v);
      v=d("pre_reset"); v.pcs=1'b1; v.cond=4'h1; v.exp=ex(1,0,0,1,1,1,0,2,4'h6,4'h6); tbl.push_back(v);
      v=d("reset_mid_it"); v.rst=1'b0; v.pcs=1'b1; v.done=1'b1; v.itstart=1'b1; v.len=3'd1; v.latch=1'b1;
      v.fw=2'b11; v.alu=4'hF; v.save=1'b1; v.exp=ex(1,0,0,1,1,1,0,2,4'h6,4'h6); tbl.push_back(v);
      v=d("post_reset"); v.pcs=1'b1; v.npc=1'b1; v.cond=4'h0; v.regw=1'b1; v.exp=ex(0,0,0,1,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      v=d("pcs_no_cr"); v.pcs=1'b1; v.exp=ex(1,0,0,0,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      // Maximum-length IT block on context 1
      v=d("itmax_start"); v.ctx=1'b1; v.itstart=1'b1; v.len=3'd4; v.pat=3'b111; v.exp=ex(1,0,0,0,0,0,0,0,4'h0,4'h0); tbl.push_back(v);
      v=d("itmax_active"); v.ctx=1'b1; v.exp=ex(0,0,0,0,0,1,0,4,4'h0,4'h0); tbl.push_back(v);

      // Initial reset, not checked
      v = d("init"); v.rst = 1'b0;
      drive(v);
      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         drive(tbl[i]);
         exp_q.push_back(tbl[i].exp);
         name_q.push_back(tbl[i].name);
         @(negedge clk);
         got = {CondEx, RegWrite, MemWrite, PCWrite, CondExR, ITActive, ITErr, ITRemain, Flags, SavedFlags};
         e = exp_q.pop_front();
         n = name_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got=%b expected=%b", n, got, e);
         end
      end

      // Walk the 4-long block down with InstrDone; ITRemain steps 4,3,2,1
      for (int k = 4; k >= 1; k--) begin
         @(posedge clk); #1;
         v = d("itmax_walk"); v.ctx = 1'b1; v.done = 1'b1;
         drive(v);
         it_q.push_back({1'b1, 3'(k)});
         @(negedge clk);
         it_got = {ITActive, ITRemain};
         it_e = it_q.pop_front();
         n_checks++;
         if (it_got !== it_e) begin
            n_fail++;
            $display("FAIL itmax_walk_%0d: got act/rem=%b expected=%b", k, it_got, it_e);
         end
      end

      // Block must close after the last retire; bounded wait
      @(posedge clk); #1;
      v = d("idle"); v.ctx = 1'b1;
      drive(v);
      budget = 8;
      while (ITActive && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      @(negedge clk);
      n_checks++;
      if (ITActive !== 1'b0 || ITRemain !== 3'd0) begin
         n_fail++;
         $display("FAIL itmax_close: got act=%b rem=%0d expected act=0 rem=0", ITActive, ITRemain);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cond_it_unit.md
COND_IT_UNIT -- requirements
Module: cond_it_unit

Interface
REQ-001 Parameter CTXW, default 1, width of the flag-context select; the unit SHALL hold NCTX = 2**CTXW independent NZCV flag contexts.
REQ-002 Parameter ITMAX, default 4, maximum number of instructions covered by one IT block; range 1..4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low (reset==0 at a rising edge resets state).
REQ-005 Cond  in  4  condition field of current instruction.
REQ-006 ALUFlags  in  4  {N,Z,C,V} from ALU.
REQ-007 FlagW  in  2  [1]=update NZ, [0]=update CV.
REQ-008 PCS, NextPC, RegW, MemW  in  1 each  raw write requests from main control FSM.
REQ-009 CondLatch  in  1  capture the evaluated condition for the rest of the instruction.
REQ-010 InstrDone  in  1  one-cycle retire strobe; advances the IT sequence.
REQ-011 CtxSel  in  CTXW  active flag context.
REQ-012 ITStart  in  1  load a new IT block; ITBase in 4 (base cond), ITLen in 3 (1..ITMAX), ITPat in 3 (bit i: 1=then, 0=else, for instruction i+2).
REQ-013 SaveFlags, RestoreFlags  in  1 each  exception entry / return.
REQ-014 PCWrite, RegWrite, MemWrite  out  1 each  gated write enables.
REQ-015 CondEx  out  1  combinational condition result; CondExR out 1 latched result.
REQ-016 Flags  out  4  flags of context CtxSel; SavedFlags out 4.
REQ-017 ITActive out 1; ITRemain out 3 (instructions left); ITErr out 1 (one-cycle pulse).

Function
REQ-018 Effective condition SHALL be Cond when ITActive==0, else the current IT condition.
REQ-019 CondEx SHALL follow the ARM table: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL=1; code 1111 SHALL evaluate as 1.
REQ-020 FlagWrite[1:0] SHALL equal FlagW & {2{CondEx}}; writes SHALL update only context CtxSel; NZ and CV bits independently enabled.
REQ-021 RegWrite = RegW & CondEx; MemWrite = MemW & CondEx; combinational, zero latency.
REQ-022 When CondLatch==1, CondExR SHALL take CondEx at the next edge; otherwise CondExR SHALL hold.
REQ-023 PCWrite SHALL equal (PCS & CondExR) | NextPC.
REQ-024 ITStart with ITActive==0 and 1<=ITLen<=ITMAX SHALL set ITActive=1, ITRemain=ITLen, current cond=ITBase at the next edge.
REQ-025 On InstrDone with ITActive==1: ITRemain decrements; if the new ITRemain>0, current cond = ITBase with bit0 XOR ~pattern bit for the next instruction; pattern shifts right by 1; ITRemain reaching 0 SHALL clear ITActive.
REQ-026 If ITBase[3:1]==3'b111, else-bits SHALL be treated as then (no inversion).
REQ-027 ITStart while ITActive==1, or with ITLen==0 or ITLen>ITMAX, SHALL be ignored and SHALL pulse ITErr for one cycle.
REQ-028 ITStart and InstrDone in the same cycle with ITActive==0: load per REQ-024; InstrDone ignored for IT counting.
REQ-029 ITStart and InstrDone in the same cycle with ITActive==1: InstrDone advances per REQ-025; ITStart rejected per REQ-027.
REQ-030 SaveFlags SHALL copy Flags (context CtxSel, pre-edge value) into SavedFlags.
REQ-031 RestoreFlags SHALL write SavedFlags into context CtxSel, overriding any same-cycle FlagWrite to that context.
REQ-032 SaveFlags and RestoreFlags together SHALL swap: SavedFlags gets old context value, context gets old SavedFlags.
REQ-033 CtxSel change SHALL switch Flags and CondEx combinationally in the same cycle; non-selected contexts hold.

Reset
REQ-034 On reset==0: all contexts=4'b0000, SavedFlags=0, CondExR=0, ITActive=0, ITRemain=0, pattern=0, ITErr=0.
REQ-035 Reset SHALL abort an in-progress IT block; reset has priority over every other input.
REQ-036 After reset, PCWrite = NextPC until CondExR is set.

Verification
REQ-037 Reset, Cond=0000(EQ), RegW=1 -> CondEx=0, RegWrite=0; ALUFlags=0100, FlagW=11, Cond=1110 -> next cycle Flags=0100; then Cond=0000 -> RegWrite=1.
REQ-038 ITStart, ITBase=0000, ITLen=3, ITPat=010 -> conds EQ, NE, EQ on successive InstrDone; ITActive=0 after third InstrDone; with Z=1 RegWrite pattern 1,0,1.
REQ-039 ITStart while active -> ITErr=1 one cycle, ITRemain unchanged; ITLen=0 -> ITErr=1, ITActive stays 0.
REQ-040 CtxSel=0 flags 1000, CtxSel=1 flags 0010; toggle CtxSel -> Flags toggles 1000/0010 with no writes; Cond=0100(MI) CondEx 1/0.
REQ-041 Context 0=0110, SavedFlags=1001, SaveFlags+RestoreFlags same cycle -> context 0=1001, SavedFlags=0110; RestoreFlags with FlagW=11 -> restore wins.
REQ-042 CondLatch with CondEx=1, then flags change so CondEx=0, PCS=1 -> PCWrite=1; reset mid-IT (ITRemain=2) -> ITActive=0, CondExR=0, PCWrite=NextPC.
